// File: rtl/ysyx_25020047_ctrl_pkg.sv
// Shared types and constants for the multi-cycle core controller.
// The state encoding, the halt codes and the default watchdog width live here.
package ysyx_25020047_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_HALT
    } ctrl_state_t;

    localparam logic [1:0] HC_NONE    = 2'b00;
    localparam logic [1:0] HC_EBREAK  = 2'b01;
    localparam logic [1:0] HC_ILLEGAL = 2'b10;
    localparam logic [1:0] HC_BUS     = 2'b11;

    localparam int CTRL_TIMEOUT_W = 8;

endpackage

// File: rtl/ysyx_25020047_wdog.sv
// Bus-wait watchdog: counts enabled cycles and flags the cycle in which the
// count reaches 2^TIMEOUT_W-1, so the owner can leave on that same edge.
module ysyx_25020047_wdog #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] LAST  = LIMIT - 1'b1;

    logic [TIMEOUT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != LIMIT)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // The count becomes LIMIT on the coming edge: this is the expiry cycle.
    assign expired = en && (cnt_reg == LAST);

endmodule

// File: rtl/ysyx_25020047_ctrl.sv
// Multi-cycle controller sequencing fetch/decode/execute/memory/write-back.
// All outputs are decoded from registered state; halts are sticky until reset.
module ysyx_25020047_ctrl
    import ysyx_25020047_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = CTRL_TIMEOUT_W,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ifu_req_valid,
    input  logic                 ifu_req_ready,
    input  logic                 ifu_rsp_valid,
    input  logic                 ifu_rsp_err,
    output logic                 inst_latch,
    input  logic                 dec_load,
    input  logic                 dec_store,
    input  logic                 dec_ebreak,
    input  logic                 dec_illegal,
    output logic                 lsu_req_valid,
    input  logic                 lsu_req_ready,
    output logic                 lsu_req_wen,
    input  logic                 lsu_rsp_valid,
    input  logic                 lsu_rsp_err,
    output logic                 reg_wen,
    output logic                 pc_wen,
    output logic                 halt,
    output logic [1:0]           halt_code,
    output logic [INSTRET_W-1:0] instret
);

    ctrl_state_t          state_reg, state_next;
    logic [1:0]           halt_code_reg, halt_code_next;
    logic [INSTRET_W-1:0] instret_reg;
    logic                 is_mem_reg;
    logic                 is_store_reg;
    logic                 retire;
    logic                 wdog_en;
    logic                 wdog_clr;
    logic                 wdog_expired;

    ysyx_25020047_wdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdog_clr),
        .en      (wdog_en),
        .expired (wdog_expired)
    );

    assign wdog_en  = (state_reg == S_FETCH_REQ) || (state_reg == S_FETCH_WAIT) ||
                      (state_reg == S_MEM_REQ)   || (state_reg == S_MEM_WAIT);
    assign wdog_clr = (state_next != state_reg);

    // ebreak retires without passing through WB; an illegal word never retires.
    assign retire = (state_reg == S_WB) ||
                    ((state_reg == S_DECODE) && !dec_illegal && dec_ebreak);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            halt_code_reg <= HC_NONE;
            instret_reg   <= '0;
            is_mem_reg    <= 1'b0;
            is_store_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            halt_code_reg <= halt_code_next;
            instret_reg   <= instret_reg + INSTRET_W'(retire);
            if (state_reg == S_DECODE) begin
                is_mem_reg   <= dec_load || dec_store;
                is_store_reg <= dec_store;
            end
        end
    end

    // Handshakes and responses are tested before the watchdog so they win a tie.
    always_comb begin
        state_next     = state_reg;
        halt_code_next = halt_code_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_FETCH_REQ;
            end
            S_FETCH_REQ: begin
                if (ifu_req_ready) begin
                    state_next = S_FETCH_WAIT;
                end else if (wdog_expired) begin
                    state_next     = S_HALT;
                    halt_code_next = HC_BUS;
                end
            end
            S_FETCH_WAIT: begin
                if (ifu_rsp_valid) begin
                    if (ifu_rsp_err) begin
                        state_next     = S_HALT;
                        halt_code_next = HC_BUS;
                    end else begin
                        state_next = S_DECODE;
                    end
                end else if (wdog_expired) begin
                    state_next     = S_HALT;
                    halt_code_next = HC_BUS;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_next     = S_HALT;
                    halt_code_next = HC_ILLEGAL;
                end else if (dec_ebreak) begin
                    state_next     = S_HALT;
                    halt_code_next = HC_EBREAK;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = is_mem_reg ? S_MEM_REQ : S_WB;
            end
            S_MEM_REQ: begin
                if (lsu_req_ready) begin
                    state_next = S_MEM_WAIT;
                end else if (wdog_expired) begin
                    state_next     = S_HALT;
                    halt_code_next = HC_BUS;
                end
            end
            S_MEM_WAIT: begin
                if (lsu_rsp_valid) begin
                    if (lsu_rsp_err) begin
                        state_next     = S_HALT;
                        halt_code_next = HC_BUS;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wdog_expired) begin
                    state_next     = S_HALT;
                    halt_code_next = HC_BUS;
                end
            end
            S_WB: begin
                state_next = start ? S_FETCH_REQ : S_IDLE;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // inst_latch marks the DECODE cycle, when the fetched word is presented.
    always_comb begin
        ifu_req_valid = (state_reg == S_FETCH_REQ);
        inst_latch    = (state_reg == S_DECODE);
        lsu_req_valid = (state_reg == S_MEM_REQ);
        lsu_req_wen   = (state_reg == S_MEM_REQ) && is_store_reg;
        reg_wen       = (state_reg == S_WB) && !is_store_reg;
        pc_wen        = (state_reg == S_WB);
        halt          = (state_reg == S_HALT);
        halt_code     = halt_code_reg;
        instret       = instret_reg;
    end

endmodule
